// File: rtl/bcd_score_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : bcd_score_accumulator
// Description : Packed-BCD score with digit-serial add/subtract of 0..9 points,
//               session high score and overflow/underflow/new-high pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_score_accumulator #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  clear_high,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_sub,
    input  logic [3:0]            req_value,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   high_score,
    output logic                  done,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  new_high
);

    localparam int C_W     = 4 * DIGITS;
    localparam int C_IDX_W = $clog2(DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [C_W-1:0]     r_work;
    logic [C_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic               r_sub;
    logic [3:0]         r_op;

    logic [3:0]         w_digit;
    logic [3:0]         w_op;
    logic [4:0]         w_add;
    logic [4:0]         w_dif;
    logic [3:0]         w_res;
    logic               w_carry_next;
    logic [C_W-1:0]     w_work_next;
    logic [C_W-1:0]     w_new_score;
    logic               w_accept;
    logic               w_commit;
    logic               w_last;

    assign w_last   = (r_idx == C_IDX_W'(DIGITS - 1));
    assign w_accept = req_valid && req_ready;
    assign w_commit = (r_state == ST_COMMIT) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        if (clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    req_ready = rst_n;
                    if (req_valid && rst_n) begin
                        w_state_next = ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (w_last) begin
                        w_state_next = ST_COMMIT;
                    end
                end
                ST_COMMIT: w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // One digit of the working register per CALC cycle; only digit 0 sees the operand.
    always_comb begin
        w_digit     = 4'd0;
        w_work_next = r_work;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == C_IDX_W'(k)) begin
                w_digit = r_work[4*k +: 4];
            end
        end
        w_op         = (r_idx == '0) ? r_op : 4'd0;
        w_add        = {1'b0, w_digit} + {1'b0, w_op} + {4'd0, r_carry};
        w_dif        = {1'b0, w_digit} - {1'b0, w_op} - {4'd0, r_carry};
        w_res        = 4'd0;
        w_carry_next = 1'b0;
        if (r_sub) begin
            if (w_dif[4]) begin
                w_res        = 4'(w_dif + 5'd10);
                w_carry_next = 1'b1;
            end else begin
                w_res = w_dif[3:0];
            end
        end else begin
            if (w_add > 5'd9) begin
                w_res        = 4'(w_add - 5'd10);
                w_carry_next = 1'b1;
            end else begin
                w_res = w_add[3:0];
            end
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == C_IDX_W'(k)) begin
                w_work_next[4*k +: 4] = w_res;
            end
        end
    end

    always_comb begin
        w_new_score = r_work;
        if (r_carry) begin
            if (r_sub) begin
                w_new_score = '0;
            end else if (SATURATE) begin
                w_new_score = {DIGITS{4'h9}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score      <= '0;
            high_score <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            new_high   <= 1'b0;
            r_work     <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_sub      <= 1'b0;
            r_op       <= 4'd0;
        end else begin
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            new_high  <= 1'b0;
            if (clear) begin
                score <= '0;
            end else if (w_accept) begin
                r_sub   <= req_sub;
                r_op    <= (req_value > 4'd9) ? 4'd9 : req_value;
                r_idx   <= '0;
                r_carry <= 1'b0;
                r_work  <= score;
            end else if (r_state == ST_CALC) begin
                r_work  <= w_work_next;
                r_carry <= w_carry_next;
                r_idx   <= r_idx + 1'b1;
            end else if (w_commit) begin
                score     <= w_new_score;
                done      <= 1'b1;
                overflow  <= !r_sub && r_carry;
                underflow <= r_sub && r_carry;
            end
            // Packed BCD orders the same as its numeric value, so a plain compare works.
            if (clear_high) begin
                high_score <= '0;
            end else if (w_commit && (w_new_score > high_score)) begin
                high_score <= w_new_score;
                new_high   <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_score_accumulator.sv
`default_nettype none
// Self-checking bench for bcd_score_accumulator at DIGITS=3, with a saturating
// and a wrapping instance driven by the same inputs.
module tb_bcd_score_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        clear_high;
    logic        req_valid;
    logic        req_sub;
    logic [3:0]  req_value;
    logic        req_ready;
    logic [11:0] score;
    logic [11:0] high_score;
    logic        done;
    logic        overflow;
    logic        underflow;
    logic        new_high;
    logic        w_req_ready;
    logic [11:0] w_score;
    logic [11:0] w_high_score;
    logic        w_done;
    logic        w_overflow;
    logic        w_underflow;
    logic        w_new_high;

    int total = 0;
    int bad   = 0;

    bcd_score_accumulator #(.DIGITS(3), .SATURATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .clear_high(clear_high),
        .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
        .req_value(req_value), .score(score), .high_score(high_score),
        .done(done), .overflow(overflow), .underflow(underflow), .new_high(new_high)
    );

    bcd_score_accumulator #(.DIGITS(3), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear), .clear_high(clear_high),
        .req_valid(req_valid), .req_ready(w_req_ready), .req_sub(req_sub),
        .req_value(req_value), .score(w_score), .high_score(w_high_score),
        .done(w_done), .overflow(w_overflow), .underflow(w_underflow), .new_high(w_new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          preset;
        logic        sub;
        logic [3:0]  val;
        logic [11:0] exp_score;
        logic        exp_ovf;
        logic        exp_unf;
        logic        exp_nh;
        logic [11:0] exp_high;
        logic [11:0] exp_wscore;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one request from an idle-ish point; returns edges from accept to done (99 = timeout).
    task automatic do_op(input logic sub, input logic [3:0] val, output int lat);
        lat = 99;
        for (int k = 0; k < 20 && !req_ready; k++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1;
        req_sub   = sub;
        req_value = val;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Zeroes score and high score, then builds the target score with ascending adds.
    task automatic preset(input int p);
        int lat;
        clear      = 1'b1;
        clear_high = 1'b1;
        @(posedge clk); #1;
        clear      = 1'b0;
        clear_high = 1'b0;
        for (int k = 0; k < p / 9; k++) begin
            do_op(1'b0, 4'd9, lat);
            if (lat != 4) begin
                total++;
                bad++;
                $display("FAIL preset latency: got %0d expected 4", lat);
            end
        end
        if (p % 9 != 0) begin
            do_op(1'b0, 4'(p % 9), lat);
            if (lat != 4) begin
                total++;
                bad++;
                $display("FAIL preset latency: got %0d expected 4", lat);
            end
        end
    endtask

    initial begin
        int lat;
        int lows;
        int dones;

        //           preset sub  val    score   ovf   unf   nh    high    wrapped
        vecs[0]  = '{0,   1'b0, 4'd7, 12'h007, 1'b0, 1'b0, 1'b1, 12'h007, 12'h007};
        vecs[1]  = '{95,  1'b0, 4'd9, 12'h104, 1'b0, 1'b0, 1'b1, 12'h104, 12'h104};
        vecs[2]  = '{995, 1'b0, 4'd8, 12'h999, 1'b1, 1'b0, 1'b1, 12'h999, 12'h003};
        vecs[3]  = '{4,   1'b1, 4'd9, 12'h000, 1'b0, 1'b1, 1'b0, 12'h004, 12'h000};
        vecs[4]  = '{100, 1'b1, 4'd1, 12'h099, 1'b0, 1'b0, 1'b0, 12'h100, 12'h099};
        vecs[5]  = '{50,  1'b0, 4'hC, 12'h059, 1'b0, 1'b0, 1'b1, 12'h059, 12'h059};
        vecs[6]  = '{123, 1'b0, 4'd0, 12'h123, 1'b0, 1'b0, 1'b0, 12'h123, 12'h123};
        vecs[7]  = '{123, 1'b1, 4'd0, 12'h123, 1'b0, 1'b0, 1'b0, 12'h123, 12'h123};
        vecs[8]  = '{999, 1'b0, 4'd0, 12'h999, 1'b0, 1'b0, 1'b0, 12'h999, 12'h999};
        vecs[9]  = '{0,   1'b1, 4'd0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000};
        vecs[10] = '{999, 1'b1, 4'd9, 12'h990, 1'b0, 1'b0, 1'b0, 12'h999, 12'h990};
        vecs[11] = '{990, 1'b0, 4'd9, 12'h999, 1'b0, 1'b0, 1'b1, 12'h999, 12'h999};
        vecs[12] = '{1,   1'b1, 4'd1, 12'h000, 1'b0, 1'b0, 1'b0, 12'h001, 12'h000};
        vecs[13] = '{109, 1'b0, 4'd1, 12'h110, 1'b0, 1'b0, 1'b1, 12'h110, 12'h110};
        vecs[14] = '{0,   1'b1, 4'hF, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000};

        rst_n      = 1'b0;
        clear      = 1'b0;
        clear_high = 1'b0;
        req_valid  = 1'b0;
        req_sub    = 1'b0;
        req_value  = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset score", 32'(score), 32'h0);
        check("reset high", 32'(high_score), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        check("ready after reset", 32'(req_ready), 32'h1);

        foreach (vecs[i]) begin
            preset(vecs[i].preset);
            do_op(vecs[i].sub, vecs[i].val, lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd4);
            check($sformatf("v%0d score", i), 32'(score), 32'(vecs[i].exp_score));
            check($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("v%0d underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
            check($sformatf("v%0d new_high", i), 32'(new_high), 32'(vecs[i].exp_nh));
            check($sformatf("v%0d high", i), 32'(high_score), 32'(vecs[i].exp_high));
            check($sformatf("v%0d wrap score", i), 32'(w_score), 32'(vecs[i].exp_wscore));
            check($sformatf("v%0d wrap overflow", i), 32'(w_overflow), 32'(vecs[i].exp_ovf));
            @(posedge clk); #1;
            check($sformatf("v%0d done one cycle", i), 32'(done), 32'h0);
        end

        // ready stays low for DIGITS+1 cycles after accept
        preset(0);
        req_valid = 1'b1; req_sub = 1'b0; req_value = 4'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lows = 0;
        for (int n = 0; n < 4; n++) begin
            if (!req_ready) lows++;
            @(posedge clk); #1;
        end
        check("busy ready low cycles", 32'(lows), 32'd4);
        check("busy ready back", 32'(req_ready), 32'h1);
        check("busy done", 32'(done), 32'h1);
        check("busy score", 32'(score), 32'h003);

        // clear during the second CALC cycle discards the operation
        preset(50);
        req_valid = 1'b1; req_sub = 1'b0; req_value = 4'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear mid score", 32'(score), 32'h0);
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("clear mid no done", 32'(dones), 32'd0);
        check("clear mid high kept", 32'(high_score), 32'h050);
        check("clear mid ready", 32'(req_ready), 32'h1);

        // clear together with req_valid: request must not be accepted
        clear = 1'b1; req_valid = 1'b1; req_sub = 1'b0; req_value = 4'd5;
        #1;
        check("clear ready low", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        clear = 1'b0; req_valid = 1'b0;
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("clear+valid no done", 32'(dones), 32'd0);
        check("clear+valid score", 32'(score), 32'h0);

        // clear_high coinciding with commit wins
        preset(20);
        req_valid = 1'b1; req_sub = 1'b0; req_value = 4'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        clear_high = 1'b1;
        @(posedge clk); #1;
        clear_high = 1'b0;
        check("clrhigh commit done", 32'(done), 32'h1);
        check("clrhigh commit score", 32'(score), 32'h025);
        check("clrhigh commit new_high", 32'(new_high), 32'h0);
        check("clrhigh commit high", 32'(high_score), 32'h0);

        // asynchronous reset in the middle of CALC
        preset(50);
        req_valid = 1'b1; req_sub = 1'b0; req_value = 4'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async rst score", 32'(score), 32'h0);
        check("async rst high", 32'(high_score), 32'h0);
        check("async rst ready", 32'(req_ready), 32'h0);
        check("async rst pulses", 32'({done, overflow, underflow, new_high}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("after rst ready", 32'(req_ready), 32'h1);
        do_op(1'b0, 4'd3, lat);
        check("after rst latency", 32'(lat), 32'd4);
        check("after rst score", 32'(score), 32'h003);
        check("after rst high", 32'(high_score), 32'h003);
        check("after rst new_high", 32'(new_high), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
